// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed CPU load/store requests into
// word-indexed memory accesses. Handles byte/half/word sizes, sign or zero
// extension on loads, and read-modify-write for sub-word stores.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RD     = 3'd1;
  localparam logic [2:0] WR     = 3'd2;
  localparam logic [2:0] RMW_RD = 3'd3;
  localparam logic [2:0] RMW_WR = 3'd4;
  localparam logic [2:0] RESP   = 3'd5;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // 33-bit compare so a MEM_WORDS near 2^30 cannot overflow the limit
  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

  logic [2:0]  state_q, state_d;
  logic        write_q, unsigned_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, word_q;
  logic        accept, req_err;
  logic [31:0] load_data, merged;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // Request legality: illegal size, misalignment or address beyond the memory
  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'b11) req_err = 1'b1;
    if (req_size == SZ_HALF && req_addr[0] != 1'b0) req_err = 1'b1;
    if (req_size == SZ_WORD && req_addr[1:0] != 2'b00) req_err = 1'b1;
    if ({1'b0, req_addr} >= ADDR_LIMIT) req_err = 1'b1;
  end

  // Next-state sequencing; every path ends in RESP, then IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err)               state_d = RESP;
          else if (!req_write)       state_d = RD;
          else if (req_size == SZ_WORD) state_d = WR;
          else                       state_d = RMW_RD;
        end
      end
      RD:      state_d = RESP;
      WR:      state_d = RESP;
      RMW_RD:  state_d = RMW_WR;
      RMW_WR:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and request holding registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      word_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q    <= req_write;
        unsigned_q <= req_unsigned;
        err_q      <= req_err;
        size_q     <= req_size;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
      end
      if (state_q == RD || state_q == RMW_RD) word_q <= mem_rdata;
    end
  end

  // Lane selection and sign/zero extension of the captured word
  always_comb begin
    case (addr_q[1:0])
      2'd0:    sel_byte = word_q[7:0];
      2'd1:    sel_byte = word_q[15:8];
      2'd2:    sel_byte = word_q[23:16];
      default: sel_byte = word_q[31:24];
    endcase
    sel_half = addr_q[1] ? word_q[31:16] : word_q[15:0];
    case (size_q)
      SZ_BYTE: load_data = {{24{!unsigned_q & sel_byte[7]}}, sel_byte};
      SZ_HALF: load_data = {{16{!unsigned_q & sel_half[15]}}, sel_half};
      default: load_data = word_q;
    endcase
  end

  // Sub-word store merge: replace only the target lane of the read word
  always_comb begin
    merged = word_q;
    if (size_q == SZ_BYTE) begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  // Memory and response outputs, zeroed whenever not meaningful
  always_comb begin
    mem_read   = (state_q == RD) || (state_q == RMW_RD);
    mem_write  = (state_q == WR) || (state_q == RMW_WR);
    mem_addr   = (mem_read || mem_write) ? {2'b00, addr_q[31:2]} : '0;
    mem_wdata  = '0;
    if (state_q == WR)     mem_wdata = wdata_q;
    if (state_q == RMW_WR) mem_wdata = merged;
    resp_valid = (state_q == RESP);
    resp_err   = resp_valid && err_q;
    resp_rdata = (resp_valid && !err_q && !write_q) ? load_data : '0;
  end

endmodule
